// File: rtl/clock_pkg.sv
// Shared state encodings, field widths/limits and display blank-mask bit
// positions for the 24-hour clock-setting controller.
package clock_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SET_HR  = 2'd1,
    SET_MIN = 2'd2
  } state_e;

  localparam logic [1:0] ST_RUN     = RUN;
  localparam logic [1:0] ST_SET_HR  = SET_HR;
  localparam logic [1:0] ST_SET_MIN = SET_MIN;

  localparam int HOURS_W   = 5;
  localparam int MINUTES_W = 6;
  localparam int SECONDS_W = 6;

  localparam logic [HOURS_W-1:0]   HOURS_MAX   = 5'd23;
  localparam logic [MINUTES_W-1:0] MINUTES_MAX = 6'd59;
  localparam logic [SECONDS_W-1:0] SECONDS_MAX = 6'd59;

  localparam int BLANK_HR_TENS  = 3;
  localparam int BLANK_HR_ONES  = 2;
  localparam int BLANK_MIN_TENS = 1;
  localparam int BLANK_MIN_ONES = 0;

  // Compare before adding so the field never leaves its legal range.
  function automatic logic [5:0] inc_wrap6(input logic [5:0] v, input logic [5:0] max_v);
    return (v >= max_v) ? 6'd0 : v + 6'd1;
  endfunction

  function automatic logic [4:0] inc_wrap5(input logic [4:0] v, input logic [4:0] max_v);
    return (v >= max_v) ? 5'd0 : v + 5'd1;
  endfunction

endpackage

// File: rtl/btn_rise_detect.sv
// One-cycle rise pulse from a debounced, synchronised button level.
// A button already held when reset releases is ignored until it is let go.
module btn_rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic rise
);

  logic btn_q_reg;
  logic block_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      btn_q_reg <= 1'b0;
      block_reg <= btn;
    end else begin
      btn_q_reg <= btn;
      if (!btn)
        block_reg <= 1'b0;
    end
  end

  assign rise = btn & ~btn_q_reg & ~block_reg & ~rst;

endmodule

// File: rtl/clock_set_controller.sv
// Hours/minutes/seconds registers of the 24-hour clock with two-button editing,
// blink mask for the edited field and idle timeout. AUTO_REPEAT_EN adds held-inc repeat.
module clock_set_controller
  import clock_pkg::*;
#(
  parameter int unsigned BLINK_DIV = 12_500_000,
  parameter int unsigned TIMEOUT_S = 30
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick_1hz,
  input  logic                 btn_mode,
  input  logic                 btn_inc,
  output logic [HOURS_W-1:0]   hours,
  output logic [MINUTES_W-1:0] minutes,
  output logic [SECONDS_W-1:0] seconds,
  output logic [3:0]           blank_mask,
  output logic [1:0]           state_o
);

  localparam logic [23:0] BLINK_LAST   = 24'(BLINK_DIV - 1);
  localparam logic [5:0]  TIMEOUT_LAST = (TIMEOUT_S == 0) ? 6'd0 : 6'(TIMEOUT_S - 1);

  logic [1:0]           state_reg, state_next;
  logic [HOURS_W-1:0]   hours_reg, hours_next;
  logic [MINUTES_W-1:0] minutes_reg, minutes_next;
  logic [SECONDS_W-1:0] seconds_reg, seconds_next;
  logic [5:0]           timeout_reg, timeout_next;
  logic [23:0]          blink_cnt_reg;
  logic                 blink_phase_reg, blink_phase_next;
  logic [3:0]           blank_mask_reg, blank_mask_next;
  logic                 mode_rise, inc_rise, inc_ev, timeout_hit;

  btn_rise_detect u_mode_rise (.clk(clk), .rst(rst), .btn(btn_mode), .rise(mode_rise));
  btn_rise_detect u_inc_rise  (.clk(clk), .rst(rst), .btn(btn_inc),  .rise(inc_rise));

`ifdef AUTO_REPEAT_EN
  localparam logic [25:0] HOLD_LAST = 26'(2 * BLINK_DIV - 1);
  localparam logic [25:0] REP_LAST  = (BLINK_DIV / 2 > 1) ? 26'(BLINK_DIV / 2 - 1) : 26'd0;

  logic [25:0] rep_cnt_reg;
  logic        repeating_reg;
  logic        auto_step;

  assign auto_step = (state_reg != ST_RUN) && btn_inc &&
                     (rep_cnt_reg == (repeating_reg ? REP_LAST : HOLD_LAST));

  always_ff @(posedge clk) begin
    if (rst) begin
      rep_cnt_reg   <= '0;
      repeating_reg <= 1'b0;
    end else if (!btn_inc || state_reg == ST_RUN || state_next != state_reg) begin
      rep_cnt_reg   <= '0;
      repeating_reg <= 1'b0;
    end else if (auto_step) begin
      rep_cnt_reg   <= '0;
      repeating_reg <= 1'b1;
    end else begin
      rep_cnt_reg   <= rep_cnt_reg + 26'd1;
    end
  end

  assign inc_ev = inc_rise | auto_step;
`else
  assign inc_ev = inc_rise;
`endif

  assign timeout_hit = (TIMEOUT_S != 0) && (state_reg != ST_RUN) && tick_1hz &&
                       (timeout_reg == TIMEOUT_LAST);
  assign blink_phase_next = (blink_cnt_reg == BLINK_LAST) ? ~blink_phase_reg : blink_phase_reg;

  always_comb begin
    state_next   = state_reg;
    hours_next   = hours_reg;
    minutes_next = minutes_reg;
    seconds_next = seconds_reg;
    timeout_next = timeout_reg;
    case (state_reg)
      ST_SET_HR, ST_SET_MIN: begin
        // Timeout beats buttons; mode beats inc.
        if (timeout_hit) begin
          state_next   = ST_RUN;
          seconds_next = '0;
          timeout_next = '0;
        end else if (mode_rise) begin
          timeout_next = '0;
          if (state_reg == ST_SET_HR) begin
            state_next = ST_SET_MIN;
          end else begin
            state_next   = ST_RUN;
            seconds_next = '0;
          end
        end else if (inc_ev) begin
          timeout_next = '0;
          if (state_reg == ST_SET_HR)
            hours_next = inc_wrap5(hours_reg, HOURS_MAX);
          else
            minutes_next = inc_wrap6(minutes_reg, MINUTES_MAX);
        end else if (tick_1hz) begin
          timeout_next = timeout_reg + 6'd1;
        end
      end
      default: begin
        timeout_next = '0;
        if (tick_1hz) begin
          seconds_next = inc_wrap6(seconds_reg, SECONDS_MAX);
          if (seconds_reg >= SECONDS_MAX) begin
            minutes_next = inc_wrap6(minutes_reg, MINUTES_MAX);
            if (minutes_reg >= MINUTES_MAX)
              hours_next = inc_wrap5(hours_reg, HOURS_MAX);
          end
        end
        if (mode_rise)
          state_next = ST_SET_HR;
      end
    endcase
  end

  always_comb begin
    blank_mask_next = 4'b0000;
    if (state_next == ST_SET_HR) begin
      blank_mask_next[BLANK_HR_TENS] = blink_phase_next;
      blank_mask_next[BLANK_HR_ONES] = blink_phase_next;
    end else if (state_next == ST_SET_MIN) begin
      blank_mask_next[BLANK_MIN_TENS] = blink_phase_next;
      blank_mask_next[BLANK_MIN_ONES] = blink_phase_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= ST_RUN;
      hours_reg       <= '0;
      minutes_reg     <= '0;
      seconds_reg     <= '0;
      timeout_reg     <= '0;
      blink_cnt_reg   <= '0;
      blink_phase_reg <= 1'b0;
      blank_mask_reg  <= 4'b0000;
    end else begin
      state_reg       <= state_next;
      hours_reg       <= hours_next;
      minutes_reg     <= minutes_next;
      seconds_reg     <= seconds_next;
      timeout_reg     <= timeout_next;
      blink_cnt_reg   <= (blink_cnt_reg == BLINK_LAST) ? 24'd0 : blink_cnt_reg + 24'd1;
      blink_phase_reg <= blink_phase_next;
      blank_mask_reg  <= blank_mask_next;
    end
  end

  assign hours      = hours_reg;
  assign minutes    = minutes_reg;
  assign seconds    = seconds_reg;
  assign blank_mask = blank_mask_reg;
  assign state_o    = state_reg;

endmodule
